// File: rtl/mem_acc_pkg.sv
// Shared encodings, FSM state type and lane helpers for the load/store front-end.
package mem_acc_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } acc_state_t;

  // Size 2'b11 is reserved and behaves as a word everywhere, hence size[1] tests.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) || (is_word(size) && (addr_lo != 2'b00));
  endfunction

  // Drops the low address bits that a half or word access does not use.
  function automatic logic [1:0] mask_lo(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [1:0] lo;
    lo = 2'b00;
    if (size == SZ_BYTE) lo = addr_lo;
    else if (size == SZ_HALF) lo = {addr_lo[1], 1'b0};
    return lo;
  endfunction

  // Replaces the addressed byte/half lane of word with the low bits of data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  addr_lo);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_BYTE: res[{addr_lo, 3'b000} +: 8]     = data[7:0];
      SZ_HALF: res[{addr_lo[1], 4'b0000} +: 16] = data[15:0];
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_ld_align.sv
// Load lane select and sign/zero extension for the data returned by the DM.
module ld_align
  import mem_acc_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every combinational output gets a value on every path so no latch is inferred.
  always_comb begin
    byte_lane = dout[{addr_lo, 3'b000} +: 8];
    half_lane = dout[{addr_lo[1], 4'b0000} +: 16];
    result    = dout;
    case (size)
      SZ_BYTE: result = {{24{sext & byte_lane[7]}}, byte_lane};
      SZ_HALF: result = {{16{sext & half_lane[15]}}, half_lane};
      default: result = dout;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store front-end for a word-only DM, with RMW sub-word stores.
// Optional macro MEM_ACC_ALIGN_CHECK_EN: flag misaligned accesses instead of masking addr bits.
module mem_access_ctrl
  import mem_acc_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-3:0] dm_ad,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_dout
);

  acc_state_t        state;
  logic              we_r;
  logic [1:0]        size_r;
  logic              sext_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] merge_r;
  logic [DATA_W-1:0] rdata_r;
  logic              err_r;

  logic              misaligned;
  logic [1:0]        lane_lo;
  logic [DATA_W-1:0] load_word;

`ifdef MEM_ACC_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(size_r, addr_r[1:0]);
  assign lane_lo    = addr_r[1:0];
`else
  assign misaligned = 1'b0;
  assign lane_lo    = mask_lo(size_r, addr_r[1:0]);
`endif

  ld_align u_ld_align (
    .dout    (dm_dout),
    .size    (size_r),
    .sext    (sext_r),
    .addr_lo (lane_lo),
    .result  (load_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_r    <= 1'b0;
      size_r  <= SZ_BYTE;
      sext_r  <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      merge_r <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_r    <= we;
            size_r  <= size;
            sext_r  <= sext;
            addr_r  <= addr;
            wdata_r <= wdata;
            err_r   <= 1'b0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (misaligned) begin
            err_r <= 1'b1;
            state <= RESP;
          end else if (!we_r) begin
            rdata_r <= load_word;
            state   <= RESP;
          end else if (is_word(size_r)) begin
            state <= RESP;
          end else begin
            merge_r <= merge_lane(dm_dout, wdata_r, size_r, lane_lo);
            state   <= WRITE;
          end
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register only, so reset removes dm_we without waiting for a clock.
  assign ready  = (state == IDLE);
  assign done   = (state == RESP);
  assign err    = done & err_r;
  assign rdata  = rdata_r;
  assign dm_ad  = addr_r[ADDR_W-1:2];
  assign dm_din = (state == WRITE) ? merge_r : wdata_r;
  assign dm_we  = (state == WRITE) ||
                  ((state == ACCESS) && we_r && is_word(size_r) && !misaligned);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl against an arithmetic memory/lane model.
// Build with or without MEM_ACC_ALIGN_CHECK_EN to match the RTL build.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sext = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, err, dm_we;
  logic [31:0] rdata, dm_din, dm_dout;
  logic [9:0]  dm_ad;

  int vectors = 0;
  int miscompares = 0;
  int we_pulses = 0;
  int done_pulses = 0;

  logic [31:0] dm_mem  [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] ref_rdata = '0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .err(err), .dm_ad(dm_ad), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  // Behavioural DM: combinational read, clocked write.
  assign dm_dout = dm_mem[dm_ad];
  always @(posedge clk) if (dm_we) dm_mem[dm_ad] <= dm_din;

  always @(negedge clk) begin
    if (dm_we) we_pulses++;
    if (done)  done_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lane_bits(input logic [1:0] sz);
    return (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
  endfunction

  function automatic int lane_shift(input logic [1:0] sz, input logic [1:0] lo);
    if (sz == 2'd0) return int'(lo) * 8;
    if (sz == 2'd1) return (int'(lo) / 2) * 16;
    return 0;
  endfunction

  function automatic logic model_misaligned(input logic [1:0] sz, input logic [1:0] lo);
`ifdef MEM_ACC_ALIGN_CHECK_EN
    if (sz == 2'd1) return (int'(lo) % 2) != 0;
    if (sz >= 2'd2) return lo != 2'd0;
    return 1'b0;
`else
    return (sz == 2'd3) && (lo == 2'd3) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sx, input logic [1:0] lo);
    logic [31:0] v, m;
    int bits;
    bits = lane_bits(sz);
    v = w >> lane_shift(sz, lo);
    if (bits < 32) begin
      m = (32'd1 << bits) - 32'd1;
      v = v & m;
      if (sx && v[bits-1]) v = v | ~m;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] m;
    int bits, sh;
    bits = lane_bits(sz);
    sh = lane_shift(sz, lo);
    if (bits == 32) return d;
    m = ((32'd1 << bits) - 32'd1) << sh;
    return (w & ~m) | ((d << sh) & m);
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    dm_mem[idx]  = val;
    ref_mem[idx] = val;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!ready) begin
      miscompares++;
      $display("FAIL %s ready_timeout: ready=%0b required=1", tag, ready);
    end
  endtask

  task automatic do_op(input logic op_we, input logic [1:0] op_size, input logic op_sext,
                       input logic [11:0] op_addr, input logic [31:0] op_wdata, input string tag);
    int idx, exp_lat, exp_we, lat, we0;
    logic [1:0] lo;
    logic misal, got_done;
    idx = int'(op_addr[11:2]);
    lo = op_addr[1:0];
    misal = model_misaligned(op_size, lo);
    exp_we = (!misal && op_we) ? 1 : 0;
    exp_lat = (!misal && op_we && op_size < 2'd2) ? 3 : 2;
    if (!misal) begin
      if (op_we) ref_mem[idx] = model_store(ref_mem[idx], op_wdata, op_size, lo);
      else       ref_rdata    = model_load(ref_mem[idx], op_size, op_sext, lo);
    end
    wait_ready(tag);
    req = 1'b1; we = op_we; size = op_size; sext = op_sext; addr = op_addr; wdata = op_wdata;
    we0 = we_pulses;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
    addr = 12'($urandom); wdata = $urandom;
    lat = 1;
    got_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    vectors++;
    if (!got_done) begin
      miscompares++;
      $display("FAIL %s done_timeout: no done within 8 cycles", tag);
      return;
    end
    vectors++;
    if (lat !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d required %0d", tag, lat, exp_lat);
    end
    vectors++;
    if (err !== misal) begin
      miscompares++;
      $display("FAIL %s err: got %0b required %0b", tag, err, misal);
    end
    vectors++;
    if (rdata !== ref_rdata) begin
      miscompares++;
      $display("FAIL %s rdata: got %08h required %08h", tag, rdata, ref_rdata);
    end
    vectors++;
    if (we_pulses - we0 !== exp_we) begin
      miscompares++;
      $display("FAIL %s dm_we_cycles: got %0d required %0d", tag, we_pulses - we0, exp_we);
    end
    vectors++;
    if (dm_mem[idx] !== ref_mem[idx]) begin
      miscompares++;
      $display("FAIL %s dm_word[%0d]: got %08h required %08h", tag, idx, dm_mem[idx], ref_mem[idx]);
    end
  endtask

  task automatic test_reset();
    #23;
    vectors++;
    if ({ready, done, err, dm_we} !== 4'b1000 || rdata !== 32'd0 ||
        dm_ad !== 10'd0 || dm_din !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_values: ready=%0b done=%0b err=%0b dm_we=%0b rdata=%08h dm_ad=%0h dm_din=%08h required 1 0 0 0 0 0 0",
               ready, done, err, dm_we, rdata, dm_ad, dm_din);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    preload(0, 32'h8899AABB);
    do_op(1'b0, 2'd0, 1'b1, 12'h001, 32'h0, "ld_byte_sext");
    do_op(1'b0, 2'd0, 1'b0, 12'h001, 32'h0, "ld_byte_zext");
    preload(1, 32'h11223344);
    do_op(1'b1, 2'd0, 1'b0, 12'h006, 32'hFFFFFF5A, "st_byte");
    do_op(1'b0, 2'd2, 1'b0, 12'h004, 32'h0, "ld_word_after_st");
    preload(2, 32'h0);
    do_op(1'b1, 2'd1, 1'b0, 12'h00A, 32'h1234BEEF, "st_half");
    do_op(1'b0, 2'd1, 1'b1, 12'h00A, 32'h0, "ld_half_sext");
    preload(4, 32'hCAFEF00D);
    do_op(1'b1, 2'd2, 1'b0, 12'h013, 32'hDEADBEEF, "st_word_misaligned");
    do_op(1'b0, 2'd3, 1'b0, 12'h010, 32'h0, "ld_reserved_size");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      do_op(1'($urandom), 2'($urandom), 1'($urandom), 12'($urandom_range(0, 63)),
            $urandom, $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_reset_mid_rmw();
    int d0;
    preload(5, 32'h55667788);
    wait_ready("rst_mid");
    req = 1'b1; we = 1'b1; size = 2'd0; sext = 1'b0; addr = 12'h016; wdata = 32'h000000A5;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (dm_we !== 1'b1 || dm_din !== 32'h55A57788) begin
      miscompares++;
      $display("FAIL rst_mid write_phase: dm_we=%0b dm_din=%08h required 1 55a57788", dm_we, dm_din);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (dm_we !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid async_drop: dm_we=%0b ready=%0b done=%0b required 0 1 0", dm_we, ready, done);
    end
    d0 = done_pulses;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = '0;
    repeat (4) @(negedge clk);
    vectors++;
    if (done_pulses !== d0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid after_release: done_pulses=%0d ready=%0b required %0d 1", done_pulses, ready, d0);
    end
    vectors++;
    if (dm_mem[5] !== ref_mem[5] || rdata !== ref_rdata) begin
      miscompares++;
      $display("FAIL rst_mid state: dm_word=%08h rdata=%08h required %08h %08h", dm_mem[5], rdata, ref_mem[5], ref_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int accepts, dones, cyc, last_done;
    int done_cyc[3];
    logic ready_gap_ok;
    preload(6, 32'h80018002);
    ref_rdata = 32'h80018002;
    wait_ready("b2b");
    req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b1; addr = 12'h018; wdata = '0;
    accepts = 0; dones = 0; last_done = -1; ready_gap_ok = 1'b1;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (done) begin
        if (dones < 3) done_cyc[dones] = cyc;
        dones++;
        last_done = cyc;
        vectors++;
        if (rdata !== ref_rdata) begin
          miscompares++;
          $display("FAIL b2b rdata: got %08h required %08h", rdata, ref_rdata);
        end
      end
      if (last_done >= 0 && cyc == last_done + 1 && dones < 3 && !ready) ready_gap_ok = 1'b0;
      if (ready && req) accepts++;
      @(posedge clk);
      #1;
      if (accepts == 3) req = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (dones !== 3) begin
      miscompares++;
      $display("FAIL b2b done_count: got %0d required 3", dones);
    end else begin
      vectors++;
      if (done_cyc[1] - done_cyc[0] !== 3 || done_cyc[2] - done_cyc[1] !== 3) begin
        miscompares++;
        $display("FAIL b2b spacing: got %0d,%0d required 3,3",
                 done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
      end
    end
    vectors++;
    if (!ready_gap_ok) begin
      miscompares++;
      $display("FAIL b2b ready_gap: ready=0 required 1 in cycle after done");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dm_mem[i]  = $urandom;
      ref_mem[i] = dm_mem[i];
    end
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_rmw();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
